// File: rtl/riscv_pkg.sv
// Shared RV32I datapath definitions.
// Writeback source encodings and register-file geometry.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10,
        RESULT_IMM = 2'b11
    } result_src_e;

endpackage

// File: rtl/mux_result4.sv
// Writeback result selector.
// Picks ALU, load, link or immediate value for commit.
module mux_result4
    import riscv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] alu_i,
    input  logic [W-1:0] mem_i,
    input  logic [W-1:0] pc4_i,
    input  logic [W-1:0] imm_i,
    output logic [W-1:0] y_o
);

    // Pure combinational 4:1 select on the writeback source.
    always_comb begin
        y_o = '0;
        unique case (result_src_e'(sel_i))
            RESULT_ALU: y_o = alu_i;
            RESULT_MEM: y_o = mem_i;
            RESULT_PC4: y_o = pc4_i;
            RESULT_IMM: y_o = imm_i;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// RV32I integer register file with writeback mux.
// Two bypassable read ports, one debug port, write counter.
module regfile_writeback #(
    parameter int          XLEN        = riscv_pkg::XLEN,
    parameter int          NREGS       = 32,
    parameter bit          BYPASS      = 1'b1,
    parameter logic [31:0] WRCNT_RESET = 32'h0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              RegWrite,
    input  logic [1:0]                        ResultSrc,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]  A1,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]  A2,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]  A3,
    input  logic [XLEN-1:0]                   ALUResult,
    input  logic [XLEN-1:0]                   ReadData,
    input  logic [XLEN-1:0]                   PCPlus4,
    input  logic [XLEN-1:0]                   ImmExt,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]  DbgAddr,
    output logic [XLEN-1:0]                   RD1,
    output logic [XLEN-1:0]                   RD2,
    output logic [XLEN-1:0]                   Result,
    output logic [XLEN-1:0]                   DbgData,
    output logic [31:0]                       WrCount
);

    import riscv_pkg::*;

    // x0 has no storage; reads of it are forced to zero.
    logic [XLEN-1:0] rf_q [1:NREGS-1];
    logic [31:0]     wr_count_q;
    logic [31:0]     wr_count_d;
    logic            wr_en;
    logic            byp1;
    logic            byp2;

    mux_result4 #(
        .W(XLEN)
    ) u_mux (
        .sel_i(ResultSrc),
        .alu_i(ALUResult),
        .mem_i(ReadData),
        .pc4_i(PCPlus4),
        .imm_i(ImmExt),
        .y_o  (Result)
    );

    function automatic logic [XLEN-1:0] rf_read(
        input logic [REG_ADDR_W-1:0] a
    );
        logic [XLEN-1:0] v;
        v = '0;
        if (a != '0 && int'(a) < NREGS) begin
            v = rf_q[a];
        end
        return v;
    endfunction

    // A commit needs RegWrite and a real (non-x0) destination.
    always_comb begin
        wr_en      = RegWrite && (A3 != '0) && (int'(A3) < NREGS);
        wr_count_d = wr_count_q;
        if (wr_en) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    // Register array and commit counter; reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            wr_count_q <= WRCNT_RESET;
        end else begin
            if (wr_en) begin
                rf_q[A3] <= Result;
            end
            wr_count_q <= wr_count_d;
        end
    end

    // Read ports, with optional forwarding of the value being written.
    always_comb begin
        byp1    = BYPASS && wr_en && (A1 == A3);
        byp2    = BYPASS && wr_en && (A2 == A3);
        RD1     = byp1 ? Result : rf_read(A1);
        RD2     = byp2 ? Result : rf_read(A2);
        DbgData = rf_read(DbgAddr);
        if (reset) begin
            RD1     = '0;
            RD2     = '0;
            DbgData = '0;
        end
    end

    assign WrCount = wr_count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed cases plus random traffic.
// Two instances: forwarding on, and forwarding off with a preset counter.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [4:0]  A1, A2, A3, DbgAddr;
    logic [31:0] ALUResult, ReadData, PCPlus4, ImmExt;

    logic [31:0] rd1_a, rd2_a, res_a, dbg_a, cnt_a;
    logic [31:0] rd1_b, rd2_b, res_b, dbg_b, cnt_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit [31:0] m_rf [32];
    bit [31:0] m_cnt;

    always #5 clk = ~clk;

    regfile_writeback dut_a (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .A1(A1), .A2(A2), .A3(A3),
        .ALUResult(ALUResult), .ReadData(ReadData),
        .PCPlus4(PCPlus4), .ImmExt(ImmExt), .DbgAddr(DbgAddr),
        .RD1(rd1_a), .RD2(rd2_a), .Result(res_a),
        .DbgData(dbg_a), .WrCount(cnt_a)
    );

    regfile_writeback #(
        .BYPASS(1'b0),
        .WRCNT_RESET(32'hFFFF_FFFF)
    ) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .A1(A1), .A2(A2), .A3(A3),
        .ALUResult(ALUResult), .ReadData(ReadData),
        .PCPlus4(PCPlus4), .ImmExt(ImmExt), .DbgAddr(DbgAddr),
        .RD1(rd1_b), .RD2(rd2_b), .Result(res_b),
        .DbgData(dbg_b), .WrCount(cnt_b)
    );

    function automatic bit [31:0] m_res();
        case (ResultSrc)
            2'd0:    return ALUResult;
            2'd1:    return ReadData;
            2'd2:    return PCPlus4;
            default: return ImmExt;
        endcase
    endfunction

    function automatic bit [31:0] m_read(input bit [4:0] a, input bit byp);
        if (reset || a == 0) return 32'h0;
        if (byp && RegWrite && A3 != 0 && a == A3) return m_res();
        return m_rf[a];
    endfunction

    // Reference state: what the architectural registers must hold.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'h0;
            m_cnt <= 32'h0;
        end else if (RegWrite && A3 != 0) begin
            m_rf[A3] <= m_res();
            m_cnt    <= m_cnt + 32'd1;
        end
    end

    task automatic chk(input string nm, input bit [31:0] act, input bit [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.rd1", rd1_a, m_read(A1, 1'b1));
            chk("a.rd2", rd2_a, m_read(A2, 1'b1));
            chk("a.res", res_a, m_res());
            chk("a.dbg", dbg_a, m_read(DbgAddr, 1'b0));
            chk("a.cnt", cnt_a, m_cnt);
            chk("b.rd1", rd1_b, m_read(A1, 1'b0));
            chk("b.rd2", rd2_b, m_read(A2, 1'b0));
            chk("b.dbg", dbg_b, m_read(DbgAddr, 1'b0));
            chk("b.cnt", cnt_b, m_cnt + 32'hFFFF_FFFF);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; ResultSrc = 2'd0;
        A1 = 0; A2 = 0; A3 = 0; DbgAddr = 0;
        ALUResult = 0; ReadData = 0; PCPlus4 = 0; ImmExt = 0;
        cyc(); cyc();
        DbgAddr = 5'd3; #1;
        chk("rst.cnt", cnt_a, 32'h0);
        chk("rst.cntb", cnt_b, 32'hFFFF_FFFF);
        chk("rst.dbg", dbg_a, 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        // ALU writeback to x5; preset counter wraps on this write
        RegWrite = 1; A3 = 5; ResultSrc = 2'd0; ALUResult = 32'hDEADBEEF;
        cyc();
        RegWrite = 0; DbgAddr = 5; #1;
        chk("alu.x5", dbg_a, 32'hDEADBEEF);
        chk("alu.cnt", cnt_a, 32'd1);
        chk("wrap.cnt", cnt_b, 32'h0);

        // LUI-style immediate into x6
        RegWrite = 1; A3 = 6; ResultSrc = 2'd3; ImmExt = 32'h12345000;
        cyc();
        RegWrite = 0; DbgAddr = 6; #1;
        chk("imm.x6", dbg_a, 32'h12345000);
        chk("imm.cnt", cnt_a, 32'd2);

        // writes to x0 are discarded and not counted
        RegWrite = 1; A3 = 0; ResultSrc = 2'd0; ALUResult = 32'hFFFFFFFF;
        A1 = 0; #1;
        chk("x0.rd1", rd1_a, 32'h0);
        chk("x0.res", res_a, 32'hFFFFFFFF);
        cyc();
        chk("x0.cnt", cnt_a, 32'd2);
        RegWrite = 0;

        // forwarding on vs off for a same-cycle reader
        A1 = 7; A2 = 7; A3 = 7; RegWrite = 1;
        ResultSrc = 2'd1; ReadData = 32'hA5A5A5A5; #1;
        chk("byp.rd1", rd1_a, 32'hA5A5A5A5);
        chk("byp.rd2", rd2_a, 32'hA5A5A5A5);
        chk("nobyp.rd1", rd1_b, 32'h0);
        cyc();
        RegWrite = 0; #1;
        chk("nobyp.post", rd1_b, 32'hA5A5A5A5);

        // JAL link value, then same stimulus without RegWrite
        RegWrite = 1; A3 = 1; ResultSrc = 2'd2; PCPlus4 = 32'h104;
        cyc();
        RegWrite = 0; DbgAddr = 1; PCPlus4 = 32'h200;
        cyc();
        chk("jal.x1", dbg_a, 32'h104);
        chk("jal.cnt", cnt_a, 32'd4);

        // only the source selected at the edge is committed
        RegWrite = 1; A3 = 9; ResultSrc = 2'd0;
        ALUResult = 32'h111; ReadData = 32'h222;
        #3 ResultSrc = 2'd1;
        cyc();
        RegWrite = 0; DbgAddr = 9; #1;
        chk("midsel.x9", dbg_a, 32'h222);

        // asynchronous reset in the middle of a cycle
        chk_en = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1; #1;
        chk("arst.cnt", cnt_a, 32'h0);
        chk("arst.cntb", cnt_b, 32'hFFFF_FFFF);
        A1 = 5; #1;
        chk("arst.rd1", rd1_a, 32'h0);
        for (int i = 0; i < 32; i++) begin
            DbgAddr = 5'(i); #1;
            chk("arst.dbg", dbg_a, 32'h0);
        end
        cyc();
        reset = 1'b0;
        DbgAddr = 5; #1;
        chk("arst.x5", dbg_a, 32'h0);
        chk_en = 1'b1;

        // random traffic against the reference model
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 499) == 0);
            RegWrite  = ($urandom_range(0, 3) != 0);
            ResultSrc = 2'($urandom_range(0, 3));
            A3        = 5'($urandom);
            A1        = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
            A2        = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
            DbgAddr   = 5'($urandom);
            ALUResult = $urandom;
            ReadData  = $urandom;
            PCPlus4   = $urandom;
            ImmExt    = $urandom;
        end
        reset = 1'b0; RegWrite = 1'b0;
        cyc(); cyc();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
